// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp chase sequencer and the downstream 4-to-8 lamp decoder.
package lamp_pkg;

    localparam int               LAMP_IDX_W    = 4;
    localparam logic [LAMP_IDX_W-1:0] LAMP_LAST_IDX = 4'd7;
    localparam logic [LAMP_IDX_W-1:0] LAMP_CFG_IDX  = 4'd8;

    typedef enum logic {
        RUN = 1'b0,
        CFG = 1'b1
    } lamp_state_t;

    // Chase arithmetic is mod 8 on the low three bits; index 8 is never stepped into.
    function automatic logic [LAMP_IDX_W-1:0] lamp_step(input logic [2:0] idx,
                                                        input logic       down);
        logic [2:0] low;
        low = down ? (idx - 3'd1) : (idx + 3'd1);
        return {1'b0, low};
    endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// Chase-rate prescaler: emits a one-cycle tick every CLK_DIV enabled cycles.
module lamp_tick_gen #(
    parameter int CLK_DIV = 25_000_000,
    parameter int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lamp_sequencer.sv
// Chase-pattern FSM driving the lamp decoder index; parks on index 8 for config display.
// Optional ping-pong stepping is compiled in with `define LAMP_SEQ_BOUNCE_EN.
module lamp_sequencer
    import lamp_pkg::*;
#(
    parameter int CLK_DIV = 25_000_000,
    parameter int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  cfg_req,
`ifdef LAMP_SEQ_BOUNCE_EN
    input  logic                  bounce,
`endif
    output logic [LAMP_IDX_W-1:0] state_idx,
    output logic                  step_pulse,
    output logic                  cfg_active
);

    lamp_state_t           state;
    logic [LAMP_IDX_W-1:0] saved_idx;
    logic [LAMP_IDX_W-1:0] next_idx;
    logic                  step_down;
    logic                  tick;
    logic                  tick_en;
    logic                  tick_clr;
`ifdef LAMP_SEQ_BOUNCE_EN
    logic                  bdir;
`endif

    // The prescaler only runs in RUN and is held at zero across the whole config excursion.
    assign tick_en  = en && (state == RUN);
    assign tick_clr = cfg_req || (state == CFG);

    lamp_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        step_down = dir;
`ifdef LAMP_SEQ_BOUNCE_EN
        if (bounce) begin
            step_down = bdir;
        end
`endif
        next_idx = lamp_step(state_idx[2:0], step_down);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            state_idx  <= '0;
            saved_idx  <= '0;
            step_pulse <= 1'b0;
            cfg_active <= 1'b0;
`ifdef LAMP_SEQ_BOUNCE_EN
            bdir       <= 1'b0;
`endif
        end else begin
            step_pulse <= 1'b0;
            case (state)
                RUN: begin
                    // Config request wins over a coincident tick, so the pre-tick index is saved.
                    if (cfg_req) begin
                        saved_idx  <= state_idx;
                        state_idx  <= LAMP_CFG_IDX;
                        cfg_active <= 1'b1;
                        state      <= CFG;
                    end else if (tick) begin
                        state_idx  <= next_idx;
                        step_pulse <= 1'b1;
`ifdef LAMP_SEQ_BOUNCE_EN
                        if (bounce) begin
                            if (next_idx == LAMP_LAST_IDX) begin
                                bdir <= 1'b1;
                            end else if (next_idx == '0) begin
                                bdir <= 1'b0;
                            end
                        end else begin
                            bdir <= dir;
                        end
`endif
                    end
                end
                CFG: begin
                    if (!cfg_req) begin
                        state_idx  <= saved_idx;
                        cfg_active <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed self-checking bench for lamp_sequencer at CLK_DIV=4 (bounce steps with LAMP_SEQ_BOUNCE_EN).
module tb_lamp_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       cfg_req;
    logic       bounce;
    logic [3:0] state_idx;
    logic       step_pulse;
    logic       cfg_active;

    int total;
    int bad;

    lamp_sequencer #(
        .CLK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .cfg_req    (cfg_req),
`ifdef LAMP_SEQ_BOUNCE_EN
        .bounce     (bounce),
`endif
        .state_idx  (state_idx),
        .step_pulse (step_pulse),
        .cfg_active (cfg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic r, input logic e, input logic d,
                                  input logic c, input logic b);
        rst     = r;
        en      = e;
        dir     = d;
        cfg_req = c;
        bounce  = b;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int unsigned observed,
                                input int unsigned expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input int unsigned exp_idx,
                             input int unsigned exp_pulse);
        check_output({tag, ".idx"}, int'(state_idx), exp_idx);
        check_output({tag, ".pulse"}, int'(step_pulse), exp_pulse);
        check_output({tag, ".cfg"}, int'(cfg_active), (exp_idx == 8) ? 1 : 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clocks(2);
        check_all("reset", 0, 0);
        check_output("reset.cnt", int'(dut.u_tick_gen.cnt), 0);

        // Up-count: index advances on every 4th enabled edge, sequence 1..7,0.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 1; s <= 8; s++) begin
            for (int c = 1; c <= 4; c++) begin
                clocks(1);
                check_all($sformatf("up.s%0d.c%0d", s, c),
                          (c == 4) ? (s % 8) : ((s - 1) % 8), (c == 4) ? 1 : 0);
            end
        end

        // Down wrap from 0: flip of dir waits for the tick.
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        clocks(3);
        check_all("down.wait", 0, 0);
        clocks(1);
        check_all("down.wrap7", 7, 1);
        clocks(4);
        check_all("down.six", 6, 1);

        // Walk down to 3 then two more cycles so the prescaler sits at 2.
        clocks(12);
        check_all("gate.at3", 3, 1);
        clocks(2);
        check_output("gate.cnt2", int'(dut.u_tick_gen.cnt), 2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            clocks(1);
            check_all($sformatf("gate.hold%0d", i), 3, 0);
        end
        check_output("gate.cnt_held", int'(dut.u_tick_gen.cnt), 2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clocks(1);
        check_all("gate.resume1", 3, 0);
        clocks(1);
        check_all("gate.resume2", 4, 1);

        // Config entry on the same edge as the 5->6 tick.
        clocks(4);
        check_all("cfg.at5", 5, 1);
        clocks(3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        clocks(1);
        check_all("cfg.enter", 8, 0);
        clocks(3);
        check_all("cfg.park", 8, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clocks(1);
        check_all("cfg.restore", 5, 0);
        check_output("cfg.cnt0", int'(dut.u_tick_gen.cnt), 0);
        clocks(3);
        check_all("cfg.pre6", 5, 0);
        clocks(1);
        check_all("cfg.step6", 6, 1);

        // Config entry is taken with en low.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clocks(1);
        check_all("cfg.noen_enter", 8, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clocks(1);
        check_all("cfg.noen_exit", 6, 0);

        // Reset while parked on the config index.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        clocks(1);
        check_all("rstcfg.in", 8, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        clocks(1);
        check_all("rstcfg.out", 0, 0);
        check_output("rstcfg.cnt", int'(dut.u_tick_gen.cnt), 0);

`ifdef LAMP_SEQ_BOUNCE_EN
        begin
            int exp_seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
            // dir is deliberately 1 to show it is ignored while bouncing.
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            for (int s = 0; s < 15; s++) begin
                clocks(4);
                check_all($sformatf("bounce.s%0d", s), exp_seq[s], 1);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
